// File: rtl/ringosc_freq_lock_ctrl.sv
// Frequency-lock controller for the PLL ring oscillator: counts divided-osc edges
// per window of clk cycles and steps the vdd DAC code one LSB toward the target.
module ringosc_freq_lock_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WIN_W     = 16,
    parameter int unsigned CODE_W    = 8,
    parameter int unsigned CODE_INIT = 128,
    parameter int unsigned LOCK_N    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              osc_in,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic [CNT_W-1:0]  tol,
    input  logic [WIN_W-1:0]  win_len,
    output logic [CODE_W-1:0] code_out,
    output logic [CNT_W-1:0]  meas_cnt,
    output logic              win_done,
    output logic              locked,
    output logic              at_rail
);

    localparam int unsigned LK_W = $clog2(LOCK_N + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_ADJUST  = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
    localparam logic [LK_W-1:0]   LOCK_TGT = LK_W'(LOCK_N);

    logic [1:0]        state_q, state_d;
    logic [2:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [LK_W-1:0]   lock_q, lock_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic              win_done_q, win_done_d;
    logic              locked_q, locked_d;
    logic              at_rail_q, at_rail_d;

    logic              edge_c;
    logic [WIN_W-1:0]  win_load_c;
    logic [CNT_W-1:0]  lo_c;
    logic [CNT_W:0]    hi_c;
    logic              below_c;
    logic              above_c;

    // sync_q[0]/[1] form the synchronizer, sync_q[2] is the edge-detect delay
    assign edge_c     = sync_q[1] & ~sync_q[2];
    assign win_load_c = (win_len == '0) ? WIN_W'(1) : win_len;
    assign lo_c       = (tol > target_cnt) ? '0 : target_cnt - tol;
    assign hi_c       = {1'b0, target_cnt} + {1'b0, tol};
    assign below_c    = cnt_q < lo_c;
    assign above_c    = {1'b0, cnt_q} > hi_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            cnt_q      <= '0;
            win_q      <= '0;
            lock_q     <= '0;
            code_q     <= CODE_W'(CODE_INIT);
            meas_q     <= '0;
            win_done_q <= 1'b0;
            locked_q   <= 1'b0;
            at_rail_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], osc_in};
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            lock_q     <= lock_d;
            code_q     <= code_d;
            meas_q     <= meas_d;
            win_done_q <= win_done_d;
            locked_q   <= locked_d;
            at_rail_q  <= at_rail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        lock_d     = lock_q;
        code_d     = code_q;
        meas_d     = meas_q;
        win_done_d = 1'b0;
        locked_d   = locked_q;
        at_rail_d  = at_rail_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    win_d   = win_load_c;
                end
            end
            S_MEASURE: begin
                if (!en) begin
                    state_d   = S_IDLE;
                    lock_d    = '0;
                    locked_d  = 1'b0;
                    at_rail_d = 1'b0;
                end else begin
                    if (edge_c && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    win_d = win_q - WIN_W'(1);
                    if (win_q <= WIN_W'(1)) begin
                        state_d    = S_ADJUST;
                        win_done_d = 1'b1;
                    end
                end
            end
            S_ADJUST: begin
                if (!en) begin
                    state_d   = S_IDLE;
                    lock_d    = '0;
                    locked_d  = 1'b0;
                    at_rail_d = 1'b0;
                end else begin
                    meas_d  = cnt_q;
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    win_d   = win_load_c;
                    if (below_c || above_c) begin
                        lock_d   = '0;
                        locked_d = 1'b0;
                        // rail flag only when the needed step is blocked
                        if (below_c) begin
                            at_rail_d = (code_q == CODE_MAX);
                            if (code_q != CODE_MAX) begin
                                code_d = code_q + CODE_W'(1);
                            end
                        end else begin
                            at_rail_d = (code_q == '0);
                            if (code_q != '0) begin
                                code_d = code_q - CODE_W'(1);
                            end
                        end
                    end else begin
                        at_rail_d = 1'b0;
                        if (lock_q < LOCK_TGT) begin
                            lock_d = lock_q + LK_W'(1);
                        end
                        locked_d = (lock_d == LOCK_TGT);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign code_out = code_q;
    assign meas_cnt = meas_q;
    assign win_done = win_done_q;
    assign locked   = locked_q;
    assign at_rail  = at_rail_q;

endmodule

// File: tb/tb_ringosc_freq_lock_ctrl.sv
// Directed self-checking bench for ringosc_freq_lock_ctrl with a clk-derived osc_in.
module tb_ringosc_freq_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        osc_in = 1'b0;
    logic [15:0] target_cnt = '0;
    logic [15:0] tol = '0;
    logic [15:0] win_len = '0;
    logic [7:0]  code_out;
    logic [15:0] meas_cnt;
    logic        win_done;
    logic        locked;
    logic        at_rail;

    int n_cmp = 0;
    int n_err = 0;
    int osc_per = 0;
    int osc_ph = 0;

    ringosc_freq_lock_ctrl #(
        .CNT_W(16), .WIN_W(16), .CODE_W(8), .CODE_INIT(128), .LOCK_N(4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .osc_in     (osc_in),
        .target_cnt (target_cnt),
        .tol        (tol),
        .win_len    (win_len),
        .code_out   (code_out),
        .meas_cnt   (meas_cnt),
        .win_done   (win_done),
        .locked     (locked),
        .at_rail    (at_rail)
    );

    always #5 clk = ~clk;

    // osc_in: period osc_per clk cycles, ~50% duty; 0 holds it low
    initial begin
        forever begin
            @(negedge clk);
            if (osc_per == 0) begin
                osc_in = 1'b0;
                osc_ph = 0;
            end else begin
                osc_ph = (osc_ph + 1) % osc_per;
                osc_in = (osc_ph < osc_per / 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_win();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (win_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("win_done_timeout", 32'd0, 32'd1);
    endtask

    // returns one cycle after ADJUST, when the updated outputs are visible
    task automatic next_win();
        wait_win();
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit seen;

        // reset values
        osc_per = 10;
        repeat (3) @(negedge clk);
        chk("rst_code", 32'(code_out), 32'd128);
        chk("rst_meas", 32'(meas_cnt), 32'd0);
        chk("rst_win_done", 32'(win_done), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_at_rail", 32'(at_rail), 32'd0);
        rst = 1'b0;

        // in band: lock after the 4th window, code held
        win_len = 16'd100;
        target_cnt = 16'd10;
        tol = 16'd0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            next_win();
            chk($sformatf("lock_meas_w%0d", k), 32'(meas_cnt), 32'd10);
            chk($sformatf("lock_code_w%0d", k), 32'(code_out), 32'd128);
            chk($sformatf("lock_locked_w%0d", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
        end

        // drop en 50 cycles into a window
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_locked", 32'(locked), 32'd0);
        chk("abort_code", 32'(code_out), 32'd128);
        chk("abort_meas", 32'(meas_cnt), 32'd10);
        repeat (60) @(negedge clk);
        chk("abort_no_win_done", 32'(win_done), 32'd0);

        // re-enable: win_done on the (win_len+1)th rising edge after en
        en = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (win_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reen_seen", 32'(seen), 32'd1);
        chk("reen_latency", 32'(n), 32'd101);
        @(negedge clk);
        @(negedge clk);
        chk("reen_code", 32'(code_out), 32'd128);
        chk("reen_locked", 32'(locked), 32'd0);

        // below band: one LSB per window
        target_cnt = 16'd20;
        tol = 16'd2;
        for (int k = 1; k <= 12; k++) begin
            next_win();
            chk($sformatf("up_code_w%0d", k), 32'(code_out), 32'(128 + k));
            chk($sformatf("up_locked_w%0d", k), 32'(locked), 32'd0);
            chk($sformatf("up_meas_w%0d", k), 32'(meas_cnt), 32'd10);
        end

        // async reset mid-MEASURE with code at 140
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        en = 1'b0;
        #1;
        chk("arst_code", 32'(code_out), 32'd128);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_win_done", 32'(win_done), 32'd0);
        chk("arst_at_rail", 32'(at_rail), 32'd0);
        chk("arst_meas", 32'(meas_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // upper rail: no edges, large target
        osc_per = 0;
        win_len = 16'd1;
        target_cnt = 16'd1000;
        tol = 16'd0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 127; k++) next_win();
        chk("hirail_code", 32'(code_out), 32'd255);
        chk("hirail_pre_flag", 32'(at_rail), 32'd0);
        next_win();
        chk("hirail_hold", 32'(code_out), 32'd255);
        chk("hirail_flag", 32'(at_rail), 32'd1);
        chk("hirail_locked", 32'(locked), 32'd0);

        // lower rail: 2 edges per 12-cycle window against target 0
        en = 1'b0;
        @(negedge clk);
        chk("en_off_rail_clr", 32'(at_rail), 32'd0);
        osc_per = 6;
        win_len = 16'd12;
        target_cnt = 16'd0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 255; k++) next_win();
        chk("lorail_code", 32'(code_out), 32'd0);
        chk("lorail_meas", 32'(meas_cnt), 32'd2);
        chk("lorail_pre_flag", 32'(at_rail), 32'd0);
        next_win();
        chk("lorail_hold", 32'(code_out), 32'd0);
        chk("lorail_flag", 32'(at_rail), 32'd1);
        target_cnt = 16'd2;
        next_win();
        chk("inband_rail_clr", 32'(at_rail), 32'd0);
        chk("inband_code", 32'(code_out), 32'd0);

        // win_len=0 acts as 1; tol > target clamps lo to 0
        en = 1'b0;
        @(negedge clk);
        osc_per = 0;
        win_len = 16'd0;
        target_cnt = 16'd3;
        tol = 16'd5;
        repeat (6) @(negedge clk);
        en = 1'b1;
        wait_win();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wl0_pulse_%0d", k), 32'(win_done), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        next_win();
        chk("wl0_meas", 32'(meas_cnt), 32'd0);
        chk("wl0_code", 32'(code_out), 32'd0);
        chk("wl0_locked", 32'(locked), 32'd1);
        chk("wl0_at_rail", 32'(at_rail), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
